voice_scheduler: RTL

//  Polyphonic front end for the wavetable sample RAM (dpram_ctrl). Once per audio sample

---
 rtl/wt_pkg.sv | 39 +++
 rtl/voice_phase_bank.sv | 34 +++
 rtl/voice_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wt_pkg.sv
// Shared types and constants for the wavetable voice scheduler.
// Note table, data widths, FSM state encoding and the RAM byte-order helper.
package wt_pkg;

  localparam int PHASE_W  = 13;
  localparam int ADDR_W   = 15;
  localparam int SAMPLE_W = 16;

  localparam logic [PHASE_W-1:0] SCALE_TABLE [0:12] = '{
    13'd74,  13'd78,  13'd83,  13'd88,
    13'd93,  13'd99,  13'd104, 13'd111,
    13'd117, 13'd124, 13'd132, 13'd139,
    13'd148
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADVANCE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_OUT
  } state_t;

  // Out-of-range note indices map to a zero step (silent, still read).
  function automatic logic [PHASE_W-1:0] scale_of(
    input logic [3:0] kv
  );
    if (kv > 4'd12) return '0;
    return SCALE_TABLE[kv];
  endfunction

  function automatic logic [SAMPLE_W-1:0] byte_swap(
    input logic [SAMPLE_W-1:0] w
  );
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/voice_phase_bank.sv
// Per-voice 13-bit phase accumulators with a single indexed read port.
// Phases step once per frame on adv; released voices snap back to 0.
module voice_phase_bank
  import wt_pkg::*;
#(
  parameter int NV = 4
) (
  input  logic                    clk_50,
  input  logic                    ar,
  input  logic                    adv,
  input  logic [NV-1:0]           key_on,
  input  logic [4*NV-1:0]         key_val,
  input  logic [$clog2(NV)-1:0]   rd_idx,
  output logic [PHASE_W-1:0]      rd_phase
);

  logic [PHASE_W-1:0] phase [NV];

  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) begin
      for (int i = 0; i < NV; i++) phase[i] <= '0;
    end else if (adv) begin
      for (int i = 0; i < NV; i++) begin
        if (key_on[i])
          phase[i] <= phase[i] + scale_of(key_val[4*i +: 4]);
        else
          phase[i] <= '0;
      end
    end
  end

  assign rd_phase = phase[rd_idx];

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic wavetable front end: one RAM read per active voice per frame, mixed.
// VOICE_SATURATE_EN selects clamp-to-16-bit mixing instead of divide-by-NV.
module voice_scheduler
  import wt_pkg::*;
#(
  parameter int NV      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk_50,
  input  logic                ar,
  input  logic                sample_tick,
  input  logic [1:0]          wave_sel,
  input  logic [NV-1:0]       key_on,
  input  logic [4*NV-1:0]     key_val,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [SAMPLE_W-1:0] mem_dout,
  input  logic                mem_done,
  output logic [SAMPLE_W-1:0] mix_out,
  output logic                mix_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int VW = $clog2(NV);
  localparam int AW = SAMPLE_W + VW;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t              st;
  logic [VW-1:0]       v;
  logic [AW-1:0]       acc;
  logic [TW-1:0]       tcnt;
  logic [SAMPLE_W-1:0] sample;
  logic [PHASE_W-1:0]  rd_phase;
  logic [SAMPLE_W-1:0] fin;
  logic                last_v;

  voice_phase_bank #(.NV(NV)) u_bank (
    .clk_50   (clk_50),
    .ar       (ar),
    .adv      (st == S_ADVANCE),
    .key_on   (key_on),
    .key_val  (key_val),
    .rd_idx   (v),
    .rd_phase (rd_phase)
  );

  assign last_v = (v == VW'(NV-1));

`ifdef VOICE_SATURATE_EN
  // Fits in 16 bits only when every bit above bit 15 matches the sign.
  always_comb begin
    fin = acc[SAMPLE_W-1:0];
    if (acc[AW-1:SAMPLE_W-1] != {(VW+1){acc[AW-1]}})
      fin = acc[AW-1] ? 16'h8000 : 16'h7FFF;
  end
`else
  always_comb begin
    fin = acc[SAMPLE_W+VW-1:VW];
  end
`endif

  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) begin
      st          <= S_IDLE;
      v           <= '0;
      acc         <= '0;
      tcnt        <= '0;
      sample      <= '0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mem_rd    <= 1'b0;
      mix_valid <= 1'b0;
      if (sample_tick && st != S_IDLE) overrun <= 1'b1;
      unique case (st)
        S_IDLE: if (sample_tick) begin
          st   <= S_ADVANCE;
          busy <= 1'b1;
          acc  <= '0;
          v    <= '0;
        end
        S_ADVANCE: st <= S_ISSUE;
        S_ISSUE: begin
          if (key_on[v]) begin
            mem_addr <= {wave_sel, rd_phase};
            mem_rd   <= 1'b1;
            tcnt     <= '0;
            st       <= S_WAIT;
          end else if (last_v) begin
            st <= S_OUT;
          end else begin
            v <= v + 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            sample <= byte_swap(mem_dout);
            st     <= S_ACC;
          end else if (tcnt == TW'(TIMEOUT-1)) begin
            sample      <= '0;
            timeout_err <= 1'b1;
            st          <= S_ACC;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_ACC: begin
          acc <= acc + {{VW{sample[SAMPLE_W-1]}}, sample};
          if (last_v) begin
            st <= S_OUT;
          end else begin
            v  <= v + 1'b1;
            st <= S_ISSUE;
          end
        end
        S_OUT: begin
          mix_out   <= fin;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          st        <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
